// File: rtl/shift_sched.sv
// shift_sched: round-robin sequencer for a shared 32-bit barrel shifter. It issues one pass for shifts and two for rotates.
module shift_sched #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [W-1:0]  req0_data,
    input  logic [AW-1:0] req0_amt,
    input  logic [1:0]    req0_op,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [W-1:0]  req1_data,
    input  logic [AW-1:0] req1_amt,
    input  logic [1:0]    req1_op,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [W-1:0]  resp_data,
    output logic          resp_id,
    output logic [W-1:0]  sh_data,
    output logic [AW-1:0] sh_amt,
    output logic          sh_direc,
    input  logic [W-1:0]  sh_result
);
    typedef enum logic [1:0] {IDLE, PASS1, PASS2, RESP} state_t;
    state_t        state, state_nxt;
    logic [W-1:0]  data_q, acc;
    logic [AW-1:0] amt_q;
    logic [1:0]    op_q;
    logic          id_q, last_grant, grant, grant_id;
    assign grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign grant      = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = grant && !grant_id;
    assign req1_ready = grant && grant_id;
    assign resp_data  = acc;
    assign resp_id    = id_q;
    // op_q[0] is the direction of the first pass; a rotate's second pass goes the other way
    always_comb begin
        state_nxt = state;
        sh_data   = '0;
        sh_amt    = '0;
        sh_direc  = 1'b0;
        case (state)
            IDLE:  state_nxt = grant ? PASS1 : IDLE;
            PASS1: begin
                sh_data   = data_q;
                sh_amt    = amt_q;
                sh_direc  = op_q[0];
                state_nxt = (op_q[1] && amt_q != '0) ? PASS2 : RESP;
            end
            PASS2: begin
                sh_data   = data_q;
                sh_amt    = ~amt_q + 1'b1;
                sh_direc  = ~op_q[0];
                state_nxt = RESP;
            end
            default: state_nxt = resp_ready ? IDLE : RESP;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            data_q     <= '0;
            amt_q      <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            acc        <= '0;
            resp_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= (state_nxt == RESP);
            if (grant) begin
                data_q     <= grant_id ? req1_data : req0_data;
                amt_q      <= grant_id ? req1_amt : req0_amt;
                op_q       <= grant_id ? req1_op : req0_op;
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (state == PASS1) acc <= sh_result;
            if (state == PASS2) acc <= acc | sh_result;
        end
    end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed bench with a behavioural shifter and an expected-response queue.
module tb_shift_sched;
    logic        clk, rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic [4:0]  req0_amt, req1_amt;
    logic [1:0]  req0_op, req1_op;
    logic        resp_valid, resp_ready, resp_id, sh_direc;
    logic [31:0] resp_data, sh_data, sh_result;
    logic [4:0]  sh_amt;
    int          checks = 0, errors = 0;
    logic [32:0] exp_q[$];

    shift_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_id(resp_id), .sh_data(sh_data), .sh_amt(sh_amt), .sh_direc(sh_direc),
        .sh_result(sh_result)
    );

    assign sh_result = sh_direc ? (sh_data >> sh_amt) : (sh_data << sh_amt);

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        logic [63:0] dd, l, r;
        dd = {d, d};
        l  = dd << a;
        r  = dd >> a;
        case (op)
            2'd0:    model = d << a;
            2'd1:    model = d >> a;
            2'd2:    model = l[63:32];
            default: model = r[31:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on each response transfer
    always @(negedge clk) begin
        if (rst_n && req0_valid && req0_ready) exp_q.push_back({1'b0, model(req0_data, req0_amt, req0_op)});
        if (rst_n && req1_valid && req1_ready) exp_q.push_back({1'b1, model(req1_data, req1_amt, req1_op)});
        if (rst_n && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("resp_data", resp_data, e[31:0]);
                chk("resp_id", {31'd0, resp_id}, {31'd0, e[32]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input logic [31:0] d, input logic [4:0] a, input logic [1:0] op);
        bit ok;
        ok = 0;
        if (id) begin req1_valid = 1; req1_data = d; req1_amt = a; req1_op = op; end
        else begin req0_valid = 1; req0_data = d; req0_amt = a; req0_op = op; end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = id ? req1_ready : req0_ready;
        end
        chk("accept", {31'd0, ok}, 32'd1);
        step();
        if (id) begin req1_valid = 0; req1_data = '1; req1_amt = '1; end
        else begin req0_valid = 0; req0_data = '1; req0_amt = '1; end
    endtask

    task automatic wait_resp();
        bit ok;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = resp_valid && resp_ready;
        end
        chk("resp_timeout", {31'd0, ok}, 32'd1);
        step();
    endtask

    initial begin
        int n0, n1, k;
        bit g0, g1;
        logic [31:0] hold_exp;
        rst_n = 0; resp_ready = 1;
        req0_valid = 0; req0_data = 0; req0_amt = 0; req0_op = 0;
        req1_valid = 0; req1_data = 0; req1_amt = 0; req1_op = 0;
        step(); step();
        rst_n = 1;
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk("rst_sh", {sh_data[26:0], sh_amt} | {31'd0, sh_direc}, 32'd0);

        send(0, 32'h0000_0001, 5'd31, 2'd0);
        chk("sll_p1_dir", {31'd0, sh_direc}, 32'd0);
        chk("sll_p1_amt", {27'd0, sh_amt}, 32'd31);
        chk("sll_p1_valid", {31'd0, resp_valid}, 32'd0);
        step();
        chk("sll_latency", {31'd0, resp_valid}, 32'd1);
        chk("sll_value", resp_data, 32'h8000_0000);
        step();
        chk("sll_idle", {31'd0, resp_valid}, 32'd0);

        send(1, 32'h8000_0001, 5'd4, 2'd2);
        chk("rol_p1_amt", {27'd0, sh_amt}, 32'd4);
        chk("rol_p1_dir", {31'd0, sh_direc}, 32'd0);
        step();
        chk("rol_p2_amt", {27'd0, sh_amt}, 32'd28);
        chk("rol_p2_dir", {31'd0, sh_direc}, 32'd1);
        chk("rol_p2_valid", {31'd0, resp_valid}, 32'd0);
        step();
        chk("rol_latency", {31'd0, resp_valid}, 32'd1);
        chk("rol_value", resp_data, 32'h0000_0018);
        step();

        send(0, 32'h0000_000F, 5'd4, 2'd3);
        wait_resp();
        send(0, 32'h1234_5678, 5'd0, 2'd2);
        step();
        chk("rol0_no_pass2", {31'd0, resp_valid}, 32'd1);
        chk("rol0_value", resp_data, 32'h1234_5678);
        step();
        send(1, 32'hDEAD_BEEF, 5'd13, 2'd1);
        wait_resp();
        send(1, 32'hDEAD_BEEF, 5'd0, 2'd1);
        wait_resp();

        // Back-pressure: response held, competing requester not granted meanwhile
        resp_ready = 0;
        hold_exp = model(32'hA5A5_0F0F, 5'd7, 2'd1);
        send(1, 32'hA5A5_0F0F, 5'd7, 2'd1);
        req0_valid = 1; req0_data = 32'h0000_00FF; req0_amt = 5'd8; req0_op = 2'd2;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", resp_data, hold_exp);
            chk("hold_id", {31'd0, resp_id}, 32'd1);
            chk("hold_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            step();
        end
        resp_ready = 1;
        #1;
        chk("resp_exit_no_accept", {31'd0, req0_ready}, 32'd0);
        step();
        chk("after_xfer_valid", {31'd0, resp_valid}, 32'd0);
        chk("after_xfer_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 0;
        wait_resp();

        // Reset during PASS2 of a rotate issued by req0
        send(0, 32'h0F0F_0000, 5'd8, 2'd3);
        step();
        chk("ror_p2_dir", {31'd0, sh_direc}, 32'd0);
        rst_n = 0;
        step();
        rst_n = 1;
        chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_data", resp_data, 32'd0);
        chk("mid_rst_sh_amt", {27'd0, sh_amt}, 32'd0);
        chk("mid_rst_pending", exp_q.size(), 32'd1);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        req0_valid = 1; req0_data = 32'h0000_0003; req0_amt = 5'd1; req0_op = 2'd0;
        req1_valid = 1; req1_data = 32'h0000_0005; req1_amt = 5'd1; req1_op = 2'd0;
        #1;
        chk("tie_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
        step();
        req0_valid = 0; req1_valid = 0;
        wait_resp();

        // Both requesters continuously valid: grants must alternate starting with req0
        rst_n = 0;
        step(); step();
        rst_n = 1;
        n0 = 0; n1 = 0; k = 0;
        req0_valid = 1; req0_data = $urandom; req0_amt = 5'($urandom); req0_op = 2'($urandom);
        req1_valid = 1; req1_data = $urandom; req1_amt = 5'($urandom); req1_op = 2'($urandom);
        for (int c = 0; c < 100 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            g0 = req0_valid && req0_ready;
            g1 = req1_valid && req1_ready;
            if (g0 || g1) begin
                chk("grant_order", {31'd0, g1}, k % 2);
                k++;
            end
            step();
            if (g0) begin
                n0++;
                if (n0 < 4) begin req0_data = $urandom; req0_amt = 5'($urandom); req0_op = 2'($urandom); end
                else req0_valid = 0;
            end
            if (g1) begin
                n1++;
                if (n1 < 4) begin req1_data = $urandom; req1_amt = 5'($urandom); req1_op = 2'($urandom); end
                else req1_valid = 0;
            end
        end
        chk("alt_grants", n0 + n1, 32'd8);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
